// File: rtl/alu_div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and a
// width-generic two's-complement magnitude helper.
package alu_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Widest operand abs_val can handle; callers narrower than this zero-extend in.
  localparam int unsigned ABS_MAX_W = 64;

  function automatic logic [ABS_MAX_W-1:0] abs_val(input logic [ABS_MAX_W-1:0] x,
                                                   input int unsigned          w);
    logic [ABS_MAX_W-1:0] signBit;
    logic [ABS_MAX_W-1:0] mask;
    logic [ABS_MAX_W-1:0] xm;
    signBit = ABS_MAX_W'(1) << (w - 1);
    mask    = (signBit << 1) - ABS_MAX_W'(1);
    xm      = x & mask;
    return ((xm & signBit) != '0) ? ((~xm + ABS_MAX_W'(1)) & mask) : xm;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the
// divisor, keep the difference when it does not borrow.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] part_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] part_o,
  output logic             qbit_o
);

  // The shifted value needs one extra bit; the restored result always fits in WIDTH.
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    shifted = {part_i, bit_i};
    diff    = shifted[WIDTH-1:0] - divisor_i;
    qbit_o  = (shifted >= {1'b0, divisor_i});
    part_o  = qbit_o ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider with signed mode, divide-by-zero and
// signed-overflow flags, and a start/busy/done handshake.
module seq_divider
  import alu_div_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] partRem_q, partRem_d;
  logic [WIDTH-1:0] qOut_q, qOut_d;
  logic [WIDTH-1:0] rOut_q, rOut_d;
  logic             qNeg_q, qNeg_d;
  logic             rNeg_q, rNeg_d;
  logic             ovfPend_q, ovfPend_d;
  logic             done_q, done_d;
  logic             divZero_q, divZero_d;
  logic             ovf_q, ovf_d;

  logic             signedOp;
  logic [WIDTH-1:0] absA, absB;
  logic [WIDTH-1:0] stepPart;
  logic             stepQbit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .part_i   (partRem_q),
    .bit_i    (dividend_q[WIDTH-1]),
    .divisor_i(divisor_q),
    .part_o   (stepPart),
    .qbit_o   (stepQbit)
  );

  always_comb begin
    signedOp = signed_mode & SIGNED_EN;
    absA     = signedOp ? WIDTH'(abs_val(ABS_MAX_W'(A), WIDTH)) : A;
    absB     = signedOp ? WIDTH'(abs_val(ABS_MAX_W'(B), WIDTH)) : B;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    partRem_d  = partRem_q;
    qOut_d     = qOut_q;
    rOut_d     = rOut_q;
    qNeg_d     = qNeg_q;
    rNeg_d     = rNeg_q;
    ovfPend_d  = ovfPend_q;
    done_d     = 1'b0;
    divZero_d  = divZero_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (B == '0) begin
            qOut_d    = '1;
            rOut_d    = A;
            divZero_d = 1'b1;
            ovf_d     = 1'b0;
            done_d    = 1'b1;
          end else begin
            dividend_d = absA;
            divisor_d  = absB;
            qNeg_d     = signedOp & (A[WIDTH-1] ^ B[WIDTH-1]);
            rNeg_d     = signedOp & A[WIDTH-1];
            ovfPend_d  = signedOp && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
            partRem_d  = '0;
            quot_d     = '0;
            cnt_d      = CW'(WIDTH);
            state_d    = RUN;
          end
        end
      end
      RUN: begin
        partRem_d  = stepPart;
        quot_d     = {quot_q[WIDTH-2:0], stepQbit};
        dividend_d = {dividend_q[WIDTH-2:0], 1'b0};
        cnt_d      = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        // Most-negative / -1 wraps; the magnitude path already yields 100..0 rem 0.
        qOut_d    = qNeg_q ? -quot_q : quot_q;
        rOut_d    = rNeg_q ? -partRem_q : partRem_q;
        if (ovfPend_q) begin
          qOut_d = {1'b1, {(WIDTH-1){1'b0}}};
          rOut_d = '0;
        end
        ovf_d     = ovfPend_q;
        divZero_d = 1'b0;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      partRem_q  <= '0;
      qOut_q     <= '0;
      rOut_q     <= '0;
      qNeg_q     <= 1'b0;
      rNeg_q     <= 1'b0;
      ovfPend_q  <= 1'b0;
      done_q     <= 1'b0;
      divZero_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      partRem_q  <= partRem_d;
      qOut_q     <= qOut_d;
      rOut_q     <= rOut_d;
      qNeg_q     <= qNeg_d;
      rNeg_q     <= rNeg_d;
      ovfPend_q  <= ovfPend_d;
      done_q     <= done_d;
      divZero_q  <= divZero_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign Q        = qOut_q;
  assign R        = rOut_q;
  assign div_zero = divZero_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: an 8-bit signed-capable instance plus a
// 16-bit unsigned-only instance.
module tb_seq_divider;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, signedMode;
  logic [7:0] a, b;
  logic       busy, done, divZero, overflow;
  logic [7:0] q, r;

  logic        start16, sm16;
  logic [15:0] a16, b16, q16, r16;
  logic        busy16, done16, dz16, ovf16;

  int   checkCount = 0;
  int   passCount  = 0;
  int   busyCnt    = 0;
  int   doneCount  = 0;
  exp_t sbQ[$];
  exp_t monExp;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(8), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signedMode),
    .A(a), .B(b), .busy(busy), .done(done), .Q(q), .R(r),
    .div_zero(divZero), .overflow(overflow)
  );

  seq_divider #(.WIDTH(16), .SIGNED_EN(1'b0)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
    .A(a16), .B(b16), .busy(busy16), .done(done16), .Q(q16), .R(r16),
    .div_zero(dz16), .overflow(ovf16)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    if (obs === expv) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  function automatic exp_t expect8(input logic [7:0] aIn, input logic [7:0] bIn, input logic sm);
    exp_t e;
    logic signed [7:0] sa, sb;
    e.dz  = 1'b0;
    e.ovf = 1'b0;
    sa    = aIn;
    sb    = bIn;
    if (bIn == 8'h00) begin
      e.q  = 8'hFF;
      e.r  = aIn;
      e.dz = 1'b1;
    end else if (sm && aIn == 8'h80 && bIn == 8'hFF) begin
      e.q   = 8'h80;
      e.r   = 8'h00;
      e.ovf = 1'b1;
    end else if (sm) begin
      e.q = sa / sb;
      e.r = sa % sb;
    end else begin
      e.q = aIn / bIn;
      e.r = aIn % bIn;
    end
    return e;
  endfunction

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (busy === 1'b1) busyCnt++;
    if (done === 1'b1) begin
      doneCount++;
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedDone", 32'd1, 32'd0);
      end else begin
        monExp = sbQ.pop_front();
        checkOutput("Q", {24'd0, q}, {24'd0, monExp.q});
        checkOutput("R", {24'd0, r}, {24'd0, monExp.r});
        checkOutput("divZero", {31'd0, divZero}, {31'd0, monExp.dz});
        checkOutput("overflow", {31'd0, overflow}, {31'd0, monExp.ovf});
      end
    end
  end

  // Called at a negedge; leaves start asserted across exactly one posedge.
  task automatic applyStimulus(input logic [7:0] aIn, input logic [7:0] bIn,
                               input logic sm, input bit expectResult);
    busyCnt    = 0;
    a          = aIn;
    b          = bIn;
    signedMode = sm;
    start      = 1'b1;
    if (expectResult) sbQ.push_back(expect8(aIn, bIn, sm));
    @(negedge clk);
    start      = 1'b0;
    a          = 8'($urandom);
    b          = 8'($urandom);
    signedMode = 1'($urandom);
  endtask

  task automatic waitDone(input int startEdges, input int expLat, input int expBusy);
    int edges;
    edges = startEdges;
    while (done !== 1'b1 && edges < 60) begin
      @(negedge clk);
      edges++;
    end
    checkOutput("doneSeen", {31'd0, done}, 32'd1);
    checkOutput("latency", edges, expLat);
    checkOutput("busyCycles", busyCnt, expBusy);
    checkOutput("busyAtDone", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int edges;
    int doneBefore;
    logic [7:0] ra, rb;
    logic       rs;

    rst = 1'b1; start = 1'b0; signedMode = 1'b0; a = '0; b = '0;
    start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstDone", {31'd0, done}, 32'd0);
    checkOutput("rstQ", {24'd0, q}, 32'd0);
    checkOutput("rstR", {24'd0, r}, 32'd0);
    checkOutput("rstFlags", {30'd0, divZero, overflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(8'd200, 8'd7, 1'b0, 1'b1);  waitDone(1, 10, 9);
    applyStimulus(8'hF9, 8'h02, 1'b1, 1'b1);  waitDone(1, 10, 9);
    applyStimulus(8'h07, 8'hFE, 1'b1, 1'b1);  waitDone(1, 10, 9);
    applyStimulus(8'h55, 8'h00, 1'b0, 1'b1);  waitDone(1, 1, 0);
    applyStimulus(8'h55, 8'h00, 1'b1, 1'b1);  waitDone(1, 1, 0);
    applyStimulus(8'h80, 8'hFF, 1'b1, 1'b1);  waitDone(1, 10, 9);
    applyStimulus(8'h80, 8'hFF, 1'b0, 1'b1);  waitDone(1, 10, 9);

    // A start pulse while busy must neither restart nor resample operands.
    applyStimulus(8'd100, 8'd3, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    a = 8'd9; b = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(4, 10, 9);

    // Reset mid-operation aborts without a done.
    applyStimulus(8'd50, 8'd7, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abortBusy", {31'd0, busy}, 32'd0);
    checkOutput("abortQ", {24'd0, q}, 32'd0);
    checkOutput("abortR", {24'd0, r}, 32'd0);
    checkOutput("abortFlags", {29'd0, done, divZero, overflow}, 32'd0);
    rst = 1'b0;
    doneBefore = doneCount;
    repeat (14) @(negedge clk);
    checkOutput("noDoneAfterAbort", doneCount, doneBefore);
    applyStimulus(8'd50, 8'd7, 1'b0, 1'b1);   waitDone(1, 10, 9);

    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom);
      rb = (i % 5 == 0) ? 8'h00 : 8'($urandom);
      rs = 1'($urandom);
      applyStimulus(ra, rb, rs, 1'b1);
      waitDone(1, (rb == 8'h00) ? 1 : 10, (rb == 8'h00) ? 0 : 9);
    end

    // Unsigned-only build must ignore signed_mode.
    a16 = 16'd65535; b16 = 16'd255; sm16 = 1'b1; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    edges = 1;
    while (done16 !== 1'b1 && edges < 60) begin
      @(negedge clk);
      edges++;
    end
    checkOutput("w16Done", {31'd0, done16}, 32'd1);
    checkOutput("w16Latency", edges, 18);
    checkOutput("w16Q", {16'd0, q16}, 32'd257);
    checkOutput("w16R", {16'd0, r16}, 32'd0);
    checkOutput("w16Flags", {30'd0, dz16, ovf16}, 32'd0);

    repeat (3) @(negedge clk);
    checkOutput("sbDrained", sbQ.size(), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
